arp_cam_access_ctrl: RTL and testbench

Sequencer and arbiter for the 4-way ARP IPv4→MAC smart CAM. It shares the CAM's single search/write port between a lookup requester and an update (insert/delete) requester, one operation at a time. Insert victims are chosen by hit way, then lowest free way, then the 2-bit random way from the CAM's random-modulo generator. It sits between the ARP request/reply logic and the CAM storage.

---
 rtl/arp_cam_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_arp_cam_access_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_cam_access_ctrl.sv
// Purpose : sequencer/arbiter sharing the single search/write port of the
//           4-way ARP IPv4->MAC CAM between a lookup and an update requester.
// Latency : handshake at T -> search strobe T+1, lookup response T+SRCH_LAT+2,
//           write T+SRCH_LAT+2 / update response T+SRCH_LAT+3 (delete-miss T+SRCH_LAT+2).
// Backpr. : one op in flight; responses hold until Rdy, no grant until the
//           cycle after the response handshake.
// Ports   : Clk/Rst; LkpReq_* / LkpRsp_* lookup channel; UpdReq_* / UpdRsp_*
//           insert/delete channel; CamSrch_* search port; CamWr_* write port;
//           RndWay victim way from the CAM random-modulo source.
module arp_cam_access_ctrl #(
  parameter int SRCH_LAT = 2,
  parameter int KW       = 32,
  parameter int VW       = 48
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          LkpReq_Vld,
  output logic          LkpReq_Rdy,
  input  logic [KW-1:0] LkpReq_Key,
  output logic          LkpRsp_Vld,
  input  logic          LkpRsp_Rdy,
  output logic          LkpRsp_Hit,
  output logic [VW-1:0] LkpRsp_Val,
  input  logic          UpdReq_Vld,
  output logic          UpdReq_Rdy,
  input  logic          UpdReq_Op,
  input  logic [KW-1:0] UpdReq_Key,
  input  logic [VW-1:0] UpdReq_Val,
  output logic          UpdRsp_Vld,
  input  logic          UpdRsp_Rdy,
  output logic [1:0]    UpdRsp_Code,
  output logic [1:0]    UpdRsp_Way,
  output logic          CamSrch_Vld,
  output logic [KW-1:0] CamSrch_Key,
  input  logic [3:0]    CamSrch_HitMap,
  input  logic [3:0]    CamSrch_FreeMap,
  input  logic [VW-1:0] CamSrch_Val,
  output logic          CamWr_En,
  output logic [1:0]    CamWr_Way,
  output logic [KW-1:0] CamWr_Key,
  output logic [VW-1:0] CamWr_Val,
  output logic          CamWr_Valid,
  input  logic [1:0]    RndWay
);

  typedef enum logic [2:0] {IDLE, SRCH, WAIT, DECIDE, WRITE, LRSP, URSP} state_t;

  state_t        state;
  logic          prio_upd;   // 0: lookup wins a tie, 1: update wins a tie
  logic          cur_upd;    // latched op is an update
  logic          cur_del;    // latched update is a delete
  logic [KW-1:0] cur_key;
  logic [VW-1:0] cur_val;
  logic [2:0]    lat_cnt;

  logic          grant_lkp;
  logic          grant_upd;
  logic          any_hit;
  logic [1:0]    dec_way;
  logic [1:0]    dec_code;

  function automatic logic [1:0] lowest_way(input logic [3:0] map);
    if (map[0])      return 2'd0;
    else if (map[1]) return 2'd1;
    else if (map[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  // Grant is combinational so a lone requester is accepted in its first
  // valid cycle; Rst gating keeps both Rdy low while reset is held.
  assign grant_lkp = (state == IDLE) && !Rst && LkpReq_Vld && (!UpdReq_Vld || !prio_upd);
  assign grant_upd = (state == IDLE) && !Rst && UpdReq_Vld && (!LkpReq_Vld || prio_upd);
  assign LkpReq_Rdy = grant_lkp;
  assign UpdReq_Rdy = grant_upd;

  // Victim selection: hit way (overwrite), else lowest free, else random.
  // The search result is only trusted in DECIDE, where it is captured
  // straight into the write/response registers.
  assign any_hit = |CamSrch_HitMap;
  always_comb begin
    dec_way  = RndWay;
    dec_code = 2'd2;
    if (any_hit) begin
      dec_way  = lowest_way(CamSrch_HitMap);
      dec_code = 2'd0;
    end else if (|CamSrch_FreeMap) begin
      dec_way  = lowest_way(CamSrch_FreeMap);
      dec_code = 2'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      prio_upd    <= 1'b0;
      cur_upd     <= 1'b0;
      cur_del     <= 1'b0;
      cur_key     <= '0;
      cur_val     <= '0;
      lat_cnt     <= '0;
      LkpRsp_Vld  <= 1'b0;
      LkpRsp_Hit  <= 1'b0;
      LkpRsp_Val  <= '0;
      UpdRsp_Vld  <= 1'b0;
      UpdRsp_Code <= 2'd0;
      UpdRsp_Way  <= 2'd0;
      CamSrch_Vld <= 1'b0;
      CamSrch_Key <= '0;
      CamWr_En    <= 1'b0;
      CamWr_Way   <= 2'd0;
      CamWr_Key   <= '0;
      CamWr_Val   <= '0;
      CamWr_Valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lkp || grant_upd) begin
            prio_upd    <= ~prio_upd;
            cur_upd     <= grant_upd;
            cur_del     <= grant_upd & UpdReq_Op;
            cur_key     <= grant_upd ? UpdReq_Key : LkpReq_Key;
            cur_val     <= UpdReq_Val;
            CamSrch_Key <= grant_upd ? UpdReq_Key : LkpReq_Key;
            CamSrch_Vld <= 1'b1;
            state       <= SRCH;
          end
        end
        SRCH: begin
          CamSrch_Vld <= 1'b0;
          lat_cnt     <= 3'(SRCH_LAT - 1);
          state       <= (SRCH_LAT == 1) ? DECIDE : WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) state <= DECIDE;
        end
        DECIDE: begin
          if (!cur_upd) begin
            LkpRsp_Vld <= 1'b1;
            LkpRsp_Hit <= any_hit;
            LkpRsp_Val <= any_hit ? CamSrch_Val : '0;
            state      <= LRSP;
          end else if (cur_del && !any_hit) begin
            // Nothing to remove: answer without touching the CAM.
            UpdRsp_Vld  <= 1'b1;
            UpdRsp_Code <= 2'd3;
            UpdRsp_Way  <= 2'd0;
            state       <= URSP;
          end else begin
            CamWr_En    <= 1'b1;
            CamWr_Way   <= dec_way;
            CamWr_Key   <= cur_key;
            CamWr_Val   <= cur_val;
            CamWr_Valid <= ~cur_del;
            UpdRsp_Code <= dec_code;
            UpdRsp_Way  <= dec_way;
            state       <= WRITE;
          end
        end
        WRITE: begin
          CamWr_En   <= 1'b0;
          UpdRsp_Vld <= 1'b1;
          state      <= URSP;
        end
        LRSP: begin
          if (LkpRsp_Rdy) begin
            LkpRsp_Vld <= 1'b0;
            state      <= IDLE;
          end
        end
        URSP: begin
          if (UpdRsp_Rdy) begin
            UpdRsp_Vld <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_cam_access_ctrl.sv
// Directed bench for arp_cam_access_ctrl: a table of single transactions with
// hand-computed results, then backpressure, reset-mid-op and round-robin runs.
module tb_arp_cam_access_ctrl;

  localparam int SRCH_LAT = 2;
  localparam int KW = 32;
  localparam int VW = 48;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          LkpReq_Vld, LkpReq_Rdy;
  logic [KW-1:0] LkpReq_Key;
  logic          LkpRsp_Vld, LkpRsp_Rdy, LkpRsp_Hit;
  logic [VW-1:0] LkpRsp_Val;
  logic          UpdReq_Vld, UpdReq_Rdy, UpdReq_Op;
  logic [KW-1:0] UpdReq_Key;
  logic [VW-1:0] UpdReq_Val;
  logic          UpdRsp_Vld, UpdRsp_Rdy;
  logic [1:0]    UpdRsp_Code, UpdRsp_Way;
  logic          CamSrch_Vld;
  logic [KW-1:0] CamSrch_Key;
  logic [3:0]    CamSrch_HitMap, CamSrch_FreeMap;
  logic [VW-1:0] CamSrch_Val;
  logic          CamWr_En;
  logic [1:0]    CamWr_Way;
  logic [KW-1:0] CamWr_Key;
  logic [VW-1:0] CamWr_Val;
  logic          CamWr_Valid;
  logic [1:0]    RndWay;

  arp_cam_access_ctrl #(.SRCH_LAT(SRCH_LAT), .KW(KW), .VW(VW)) dut (
    .Clk(Clk), .Rst(Rst),
    .LkpReq_Vld(LkpReq_Vld), .LkpReq_Rdy(LkpReq_Rdy), .LkpReq_Key(LkpReq_Key),
    .LkpRsp_Vld(LkpRsp_Vld), .LkpRsp_Rdy(LkpRsp_Rdy), .LkpRsp_Hit(LkpRsp_Hit),
    .LkpRsp_Val(LkpRsp_Val),
    .UpdReq_Vld(UpdReq_Vld), .UpdReq_Rdy(UpdReq_Rdy), .UpdReq_Op(UpdReq_Op),
    .UpdReq_Key(UpdReq_Key), .UpdReq_Val(UpdReq_Val),
    .UpdRsp_Vld(UpdRsp_Vld), .UpdRsp_Rdy(UpdRsp_Rdy), .UpdRsp_Code(UpdRsp_Code),
    .UpdRsp_Way(UpdRsp_Way),
    .CamSrch_Vld(CamSrch_Vld), .CamSrch_Key(CamSrch_Key),
    .CamSrch_HitMap(CamSrch_HitMap), .CamSrch_FreeMap(CamSrch_FreeMap),
    .CamSrch_Val(CamSrch_Val),
    .CamWr_En(CamWr_En), .CamWr_Way(CamWr_Way), .CamWr_Key(CamWr_Key),
    .CamWr_Val(CamWr_Val), .CamWr_Valid(CamWr_Valid),
    .RndWay(RndWay)
  );

  always #5 Clk = ~Clk;

  // CAM stand-in: the scripted result is presented only in the cycle that is
  // SRCH_LAT cycles after the search strobe; every other cycle shows the bitwise
  // complement, so sampling at the wrong time gives a wrong answer.
  logic [3:0]    cur_hit, cur_free;
  logic [VW-1:0] cur_cval;
  logic [1:0]    cur_rnd;
  logic [7:0]    pipe = 8'd0;
  logic          samp;

  always @(posedge Clk) pipe <= {pipe[6:0], CamSrch_Vld};
  assign samp            = pipe[SRCH_LAT-1];
  assign CamSrch_HitMap  = samp ? cur_hit  : ~cur_hit;
  assign CamSrch_FreeMap = samp ? cur_free : ~cur_free;
  assign CamSrch_Val     = samp ? cur_cval : ~cur_cval;
  assign RndWay          = samp ? cur_rnd  : ~cur_rnd;

  typedef struct {
    logic          upd;
    logic          op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic [3:0]    hit;
    logic [3:0]    free;
    logic [VW-1:0] cval;
    logic [1:0]    rnd;
    logic          exp_hit;
    logic [VW-1:0] exp_val;
    logic [1:0]    exp_code;
    logic [1:0]    exp_way;
    logic          exp_wr;
  } vec_t;

  vec_t vecs [11];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{LkpReq_Rdy, UpdReq_Rdy, LkpRsp_Vld, LkpRsp_Hit, LkpRsp_Val,
             UpdRsp_Vld, UpdRsp_Code, UpdRsp_Way, CamSrch_Vld, CamSrch_Key,
             CamWr_En, CamWr_Way, CamWr_Key, CamWr_Val, CamWr_Valid};
  endfunction

  task automatic set_cam(input vec_t v);
    cur_hit = v.hit; cur_free = v.free; cur_cval = v.cval; cur_rnd = v.rnd;
  endtask

  // One complete transaction with responses accepted immediately.
  task automatic run_vec(input vec_t v, input int idx);
    logic got;
    int t_rsp, t_wr, n_wr, exp_rsp;
    logic r_hit; logic [VW-1:0] r_val; logic [1:0] r_code, r_way;
    logic [1:0] w_way; logic [KW-1:0] w_key; logic [VW-1:0] w_val; logic w_valid;
    string p;
    p = $sformatf("v%0d", idx);
    set_cam(v);
    @(negedge Clk);
    LkpRsp_Rdy = 1'b1; UpdRsp_Rdy = 1'b1;
    if (v.upd) begin
      UpdReq_Vld = 1'b1; UpdReq_Op = v.op; UpdReq_Key = v.key; UpdReq_Val = v.val;
    end else begin
      LkpReq_Vld = 1'b1; LkpReq_Key = v.key;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1 got = v.upd ? UpdReq_Rdy : LkpReq_Rdy;
      if (!got) @(negedge Clk);
    end
    chk({p, " grant"}, 64'(got), 64'd1);
    if (!got) begin
      LkpReq_Vld = 1'b0; UpdReq_Vld = 1'b0;
      return;
    end
    @(posedge Clk);                       // handshake edge, end of cycle T
    @(negedge Clk);                       // cycle T+1
    LkpReq_Vld = 1'b0; UpdReq_Vld = 1'b0;
    #1;
    chk({p, " srch_vld T+1"}, 64'(CamSrch_Vld), 64'd1);
    chk({p, " srch_key"}, 64'(CamSrch_Key), 64'(v.key));
    t_rsp = 0; t_wr = 0; n_wr = 0;
    r_hit = 0; r_val = 0; r_code = 0; r_way = 0;
    w_way = 0; w_key = 0; w_val = 0; w_valid = 0;
    for (int k = 2; k <= 12 && t_rsp == 0; k++) begin
      @(negedge Clk); #1;
      if (k == 2) chk({p, " srch_vld one cycle"}, 64'(CamSrch_Vld), 64'd0);
      if (CamWr_En) begin
        n_wr++; t_wr = k;
        w_way = CamWr_Way; w_key = CamWr_Key; w_val = CamWr_Val; w_valid = CamWr_Valid;
      end
      if (v.upd ? UpdRsp_Vld : LkpRsp_Vld) begin
        t_rsp = k;
        r_hit = LkpRsp_Hit; r_val = LkpRsp_Val; r_code = UpdRsp_Code; r_way = UpdRsp_Way;
      end
    end
    @(negedge Clk); #1;
    if (CamWr_En) n_wr++;
    chk({p, " rsp dropped after handshake"}, 64'(v.upd ? UpdRsp_Vld : LkpRsp_Vld), 64'd0);
    exp_rsp = (v.upd && v.exp_wr) ? SRCH_LAT + 3 : SRCH_LAT + 2;
    chk({p, " rsp cycle"}, 64'(t_rsp), 64'(exp_rsp));
    chk({p, " write count"}, 64'(n_wr), 64'(v.exp_wr));
    if (!v.upd) begin
      chk({p, " lkp hit"}, 64'(r_hit), 64'(v.exp_hit));
      chk({p, " lkp val"}, 64'(r_val), 64'(v.exp_val));
    end else begin
      chk({p, " upd code"}, 64'(r_code), 64'(v.exp_code));
      chk({p, " upd way"}, 64'(r_way), 64'(v.exp_way));
    end
    if (v.exp_wr) begin
      chk({p, " wr cycle"}, 64'(t_wr), 64'(SRCH_LAT + 2));
      chk({p, " wr way"}, 64'(w_way), 64'(v.exp_way));
      chk({p, " wr key"}, 64'(w_key), 64'(v.key));
      chk({p, " wr val"}, 64'(w_val), 64'(v.val));
      chk({p, " wr valid"}, 64'(w_valid), 64'(!v.op));
    end
  endtask

  initial begin
    logic got, seen_wr, seen_act;
    int grants;
    logic g_upd [4];

    //        upd   op    key           val                 hit      free     cval                rnd   ehit  eval                code  way   wr
    vecs[0]  = '{1'b0, 1'b0, 32'h0A000001, 48'h0,              4'b0000, 4'b1111, 48'hDEAD_BEEF_0000, 2'd0, 1'b0, 48'h0,              2'd0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0A000001, 48'h0011_2233_4455, 4'b0000, 4'b1100, 48'h0,              2'd0, 1'b0, 48'h0,              2'd1, 2'd2, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0A000001, 48'h0,              4'b0100, 4'b0000, 48'h0011_2233_4455, 2'd0, 1'b1, 48'h0011_2233_4455, 2'd0, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0A000002, 48'hAAAA_BBBB_CCCC, 4'b0000, 4'b0000, 48'h0,              2'd3, 1'b0, 48'h0,              2'd2, 2'd3, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0A000002, 48'hAAAA_BBBB_CCCC, 4'b0000, 4'b0000, 48'h0,              2'd1, 1'b0, 48'h0,              2'd2, 2'd1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0A000003, 48'h0102_0304_0506, 4'b0110, 4'b0001, 48'h0,              2'd0, 1'b0, 48'h0,              2'd0, 2'd1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h0A000004, 48'h0,              4'b0000, 4'b1111, 48'h0,              2'd2, 1'b0, 48'h0,              2'd3, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0A000005, 48'h0,              4'b1000, 4'b0000, 48'h0,              2'd0, 1'b0, 48'h0,              2'd0, 2'd3, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0A000006, 48'h0,              4'b1010, 4'b0000, 48'h1234_5678_9ABC, 2'd0, 1'b1, 48'h1234_5678_9ABC, 2'd0, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0A000007, 48'h5555_6666_7777, 4'b1001, 4'b0110, 48'h0,              2'd2, 1'b0, 48'h0,              2'd0, 2'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0A000008, 48'h0000_0000_0001, 4'b0000, 4'b1000, 48'h0,              2'd1, 1'b0, 48'h0,              2'd1, 2'd3, 1'b1};

    Rst = 1'b1;
    LkpReq_Vld = 0; LkpReq_Key = 0; LkpRsp_Rdy = 0;
    UpdReq_Vld = 0; UpdReq_Op = 0; UpdReq_Key = 0; UpdReq_Val = 0; UpdRsp_Rdy = 0;
    set_cam(vecs[0]);

    // Reset state: everything low even with both requesters pushing.
    @(negedge Clk); @(negedge Clk);
    LkpReq_Vld = 1'b1; UpdReq_Vld = 1'b1;
    #1 chk("reset outputs zero", 64'(any_out()), 64'd0);
    LkpReq_Vld = 1'b0; UpdReq_Vld = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Lookup response backpressure: held stable, no new grant while pending.
    set_cam(vecs[2]);
    @(negedge Clk);
    LkpRsp_Rdy = 1'b0; LkpReq_Vld = 1'b1; LkpReq_Key = 32'h0A000001;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1 got = LkpReq_Rdy;
      if (!got) @(negedge Clk);
    end
    chk("bp grant", 64'(got), 64'd1);
    @(posedge Clk);
    @(negedge Clk);
    LkpReq_Vld = 1'b0;
    UpdReq_Vld = 1'b1; UpdReq_Op = 1'b0; UpdReq_Key = 32'h0C000001; UpdReq_Val = 48'h1;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge Clk); #1 got = LkpRsp_Vld;
    end
    chk("bp rsp arrives", 64'(got), 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge Clk); #1; end
      chk($sformatf("bp c%0d rsp vld", c), 64'(LkpRsp_Vld), 64'd1);
      chk($sformatf("bp c%0d rsp hit", c), 64'(LkpRsp_Hit), 64'd1);
      chk($sformatf("bp c%0d rsp val", c), 64'(LkpRsp_Val), 64'h0011_2233_4455);
      chk($sformatf("bp c%0d no upd grant", c), 64'(UpdReq_Rdy), 64'd0);
    end
    LkpRsp_Rdy = 1'b1;
    @(negedge Clk); #1;
    chk("bp rsp released", 64'(LkpRsp_Vld), 64'd0);
    chk("bp upd granted after", 64'(UpdReq_Rdy), 64'd1);
    UpdReq_Vld = 1'b0;

    // Reset during WAIT of an insert.
    set_cam(vecs[10]);
    @(negedge Clk);
    UpdRsp_Rdy = 1'b1;
    UpdReq_Vld = 1'b1; UpdReq_Op = 1'b0; UpdReq_Key = 32'h0B000001; UpdReq_Val = 48'h77;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1 got = UpdReq_Rdy;
      if (!got) @(negedge Clk);
    end
    chk("rst-mid grant", 64'(got), 64'd1);
    @(posedge Clk);
    @(negedge Clk);                       // T+1 (SRCH)
    UpdReq_Vld = 1'b0;
    @(negedge Clk);                       // T+2 (WAIT)
    LkpReq_Vld = 1'b1; UpdReq_Vld = 1'b1;
    Rst = 1'b1;
    #1 chk("rst-mid outputs zero", 64'(any_out()), 64'd0);
    @(negedge Clk); @(negedge Clk);
    LkpReq_Vld = 1'b0; UpdReq_Vld = 1'b0;
    Rst = 1'b0;
    seen_wr = 1'b0; seen_act = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk); #1;
      seen_wr  |= CamWr_En;
      seen_act |= UpdRsp_Vld | LkpRsp_Vld | CamSrch_Vld;
    end
    chk("rst-mid no write after", 64'(seen_wr), 64'd0);
    chk("rst-mid no activity after", 64'(seen_act), 64'd0);

    // Round-robin with both requesters held valid; lookup first after reset.
    LkpReq_Key = 32'h0A000009; UpdReq_Key = 32'h0A00000A; UpdReq_Op = 1'b0;
    LkpReq_Vld = 1'b1; UpdReq_Vld = 1'b1;
    LkpRsp_Rdy = 1'b1; UpdRsp_Rdy = 1'b1;
    grants = 0;
    for (int c = 0; c < 80 && grants < 4; c++) begin
      #1;
      if (LkpReq_Rdy || UpdReq_Rdy) begin
        chk($sformatf("rr g%0d one-hot", grants), 64'(LkpReq_Rdy & UpdReq_Rdy), 64'd0);
        g_upd[grants] = UpdReq_Rdy;
        grants++;
      end
      @(negedge Clk);
    end
    LkpReq_Vld = 1'b0; UpdReq_Vld = 1'b0;
    chk("rr grant count", 64'(grants), 64'd4);
    for (int g = 0; g < grants; g++)
      chk($sformatf("rr g%0d is update", g), 64'(g_upd[g]), 64'(g % 2));
    repeat (10) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
